// File: rtl/pix_sched_pkg.sv
// Shared widths, default raster timing and slot-state encoding for the
// pixel memory scheduler.
package pix_sched_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   localparam int DEF_H_START = 216;
   localparam int DEF_V_START = 35;
   localparam int DEF_IMG_W   = 256;
   localparam int DEF_IMG_H   = 256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } slot_t;

endpackage

// File: rtl/pix_win_dec.sv
// Combinational image-window decode: beam position to in-window flag,
// even-column flag and doubled-pixel RAM address {m,n}.
module pix_win_dec
   import pix_sched_pkg::*;
#(
   parameter int H_START = DEF_H_START,
   parameter int V_START = DEF_V_START,
   parameter int IMG_W   = DEF_IMG_W,
   parameter int IMG_H   = DEF_IMG_H
) (
   input  logic [9:0]        filas,
   input  logic [10:0]       columnas,
   output logic              in_win,
   output logic              even,
   output logic [ADDR_W-1:0] disp_addr
);

   // One extra bit on the bounds so the window end never wraps.
   localparam logic [10:0] V_LO = 11'(V_START);
   localparam logic [10:0] V_HI = 11'(V_START + 2 * IMG_H);
   localparam logic [11:0] H_LO = 12'(H_START);
   localparam logic [11:0] H_HI = 12'(H_START + 2 * IMG_W);

   logic [9:0]  dr;
   logic [10:0] dc;
   logic [7:0]  m;
   logic [7:0]  n;

   assign dr = filas - 10'(V_START);
   assign dc = columnas - 11'(H_START);
   assign m  = 8'(dr >> 1);
   assign n  = 8'(dc >> 1);

   assign in_win = ({1'b0, filas} >= V_LO) && ({1'b0, filas} < V_HI) &&
                   ({1'b0, columnas} >= H_LO) && ({1'b0, columnas} < H_HI);
   assign even      = ~dc[0];
   assign disp_addr = {m, n};

endmodule

// File: rtl/pix_mem_sched.sv
// Slot scheduler for the single-port image RAM: display reads on even in-window
// columns, host writes in free slots. Define SCHED_BLANK_ONLY_EN to restrict host writes to out-of-window slots.
module pix_mem_sched
   import pix_sched_pkg::*;
#(
   parameter int                H_START  = DEF_H_START,
   parameter int                V_START  = DEF_V_START,
   parameter int                IMG_W    = DEF_IMG_W,
   parameter int                IMG_H    = DEF_IMG_H,
   parameter logic [DATA_W-1:0] BG_COLOR = 8'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        Filas,
   input  logic [10:0]       Columnas,
   input  logic              HostReq,
   input  logic [ADDR_W-1:0] HostAddr,
   input  logic [DATA_W-1:0] HostData,
   output logic              HostAck,
   output logic [ADDR_W-1:0] MemAddr,
   output logic              MemWe,
   output logic [DATA_W-1:0] MemWdata,
   input  logic [DATA_W-1:0] MemRdata,
   output logic [DATA_W-1:0] Pixel,
   output logic              PixelValid
);

   logic              in_win;
   logic              even;
   logic [ADDR_W-1:0] disp_addr;
   logic              host_ok;

   slot_t             slot_reg;
   slot_t             slot_next;
   logic [ADDR_W-1:0] addr_next;
   logic [DATA_W-1:0] wdata_next;

   logic              win_s1;
   logic              win_s2;
   logic              rd_s2;

   pix_win_dec #(
      .H_START (H_START),
      .V_START (V_START),
      .IMG_W   (IMG_W),
      .IMG_H   (IMG_H)
   ) u_win_dec (
      .filas     (Filas),
      .columnas  (Columnas),
      .in_win    (in_win),
      .even      (even),
      .disp_addr (disp_addr)
   );

`ifdef SCHED_BLANK_ONLY_EN
   assign host_ok = ~in_win;
`else
   assign host_ok = 1'b1;
`endif

   // Display read wins; a host grant also needs a non-ack cycle in between.
   always_comb begin
      slot_next  = IDLE;
      addr_next  = MemAddr;
      wdata_next = MemWdata;
      if (in_win && even) begin
         slot_next = RD;
         addr_next = disp_addr;
      end else if (HostReq && !HostAck && host_ok) begin
         slot_next  = WR;
         addr_next  = HostAddr;
         wdata_next = HostData;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_reg <= IDLE;
         MemAddr  <= '0;
         MemWe    <= 1'b0;
         MemWdata <= '0;
         HostAck  <= 1'b0;
      end else begin
         slot_reg <= slot_next;
         MemAddr  <= addr_next;
         MemWdata <= wdata_next;
         MemWe    <= (slot_next == WR);
         HostAck  <= (slot_next == WR);
      end
   end

   // Two-stage pixel pipe aligned to the RAM's one-cycle read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_s1     <= 1'b0;
         win_s2     <= 1'b0;
         rd_s2      <= 1'b0;
         Pixel      <= BG_COLOR;
         PixelValid <= 1'b0;
      end else begin
         win_s1     <= in_win;
         win_s2     <= win_s1;
         rd_s2      <= (slot_reg == RD);
         PixelValid <= win_s2;
         if (rd_s2) begin
            Pixel <= MemRdata;
         end else if (!win_s2) begin
            Pixel <= BG_COLOR;
         end
      end
   end

endmodule

// File: tb/tb_pix_mem_sched.sv
// Randomized self-checking bench for pix_mem_sched with a behavioural RAM and
// a cycle-level reference of the slot/pixel rules.
module tb_pix_mem_sched;
   import pix_sched_pkg::*;

   localparam int HS = 216;
   localparam int VS = 35;
   localparam int IW = 256;
   localparam int IH = 256;
   localparam logic [7:0] BG = 8'h00;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  Filas = '0;
   logic [10:0] Columnas = '0;
   logic        HostReq = 1'b0;
   logic [15:0] HostAddr = '0;
   logic [7:0]  HostData = '0;
   logic        HostAck;
   logic [15:0] MemAddr;
   logic        MemWe;
   logic [7:0]  MemWdata;
   logic [7:0]  MemRdata;
   logic [7:0]  Pixel;
   logic        PixelValid;

   always #5 clk = ~clk;

   pix_mem_sched #(
      .H_START (HS), .V_START (VS), .IMG_W (IW), .IMG_H (IH), .BG_COLOR (BG)
   ) dut (
      .clk (clk), .rst_n (rst_n), .Filas (Filas), .Columnas (Columnas),
      .HostReq (HostReq), .HostAddr (HostAddr), .HostData (HostData),
      .HostAck (HostAck), .MemAddr (MemAddr), .MemWe (MemWe),
      .MemWdata (MemWdata), .MemRdata (MemRdata), .Pixel (Pixel),
      .PixelValid (PixelValid)
   );

   function automatic logic [7:0] init_val(input int i);
      return 8'(i * 37 + (i >> 8) * 11) ^ 8'hA5;
   endfunction

   // Behavioural single-port RAM with registered read (old data on collision).
   logic [7:0] ram [65536];
   logic [7:0] rd_q;
   logic       preload = 1'b1;
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 65536; i++) ram[i] <= init_val(i);
      end else if (MemWe) begin
         ram[MemAddr] <= MemWdata;
      end
      rd_q <= ram[MemAddr];
   end
   assign MemRdata = rd_q;

   typedef struct packed {
      logic [7:0] pix;
      logic       vld;
   } pix_t;

   logic [7:0]  shadow [65536];
   int          n_chk = 0;
   int          n_pass = 0;
   logic        m_ack;
   logic [15:0] m_addr;
   logic [7:0]  m_wdata;
   logic        pend_we;
   logic [15:0] pend_addr;
   logic [7:0]  pend_data;
   logic [7:0]  last_pix;
   pix_t        pq[$];
   logic        host_req = 1'b0;
   logic [15:0] host_addr = '0;
   logic [7:0]  host_data = '0;
   int          last_kind;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
   endtask

   task automatic model_reset();
      m_ack    = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      pend_we  = 1'b0;
      last_pix = BG;
      pq.delete();
      pq.push_back('{pix: BG, vld: 1'b0});
      pq.push_back('{pix: BG, vld: 1'b0});
   endtask

   // Async reset: outputs must drop immediately, before any clock edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      chk("rst_mem_addr", 32'(MemAddr), 32'h0);
      chk("rst_mem_we", 32'(MemWe), 32'h0);
      chk("rst_mem_wdata", 32'(MemWdata), 32'h0);
      chk("rst_host_ack", 32'(HostAck), 32'h0);
      chk("rst_pixel", 32'(Pixel), 32'(BG));
      chk("rst_pixel_valid", 32'(PixelValid), 32'h0);
      @(posedge clk);
      @(negedge clk);
      preload = 1'b0;
      rst_n   = 1'b1;
      model_reset();
      $display("reset released at %0t", $time);
   endtask

   // One scheduler cycle: drive beam/host inputs, predict, clock, compare.
   task automatic do_cycle(input int f, input int c);
      int         dr;
      int         dc;
      logic       inw;
      logic       ev;
      logic       host_ok;
      logic [15:0] da;
      int         kind;
      pix_t       e;
      if (pend_we) shadow[pend_addr] = pend_data;
      pend_we  = 1'b0;
      Filas    = 10'(f);
      Columnas = 11'(c);
      HostReq  = host_req;
      HostAddr = host_addr;
      HostData = host_data;
      dr  = f - VS;
      dc  = c - HS;
      inw = (dr >= 0) && (dr < 2 * IH) && (dc >= 0) && (dc < 2 * IW);
      ev  = inw && ((dc % 2) == 0);
      da  = {8'((dr / 2) % 256), 8'((dc / 2) % 256)};
`ifdef SCHED_BLANK_ONLY_EN
      host_ok = !inw;
`else
      host_ok = 1'b1;
`endif
      kind = 0;
      if (inw && ev) begin
         kind   = 1;
         m_addr = da;
      end else if (host_req && !m_ack && host_ok) begin
         kind      = 2;
         m_addr    = host_addr;
         m_wdata   = host_data;
         pend_we   = 1'b1;
         pend_addr = host_addr;
         pend_data = host_data;
      end
      m_ack = (kind == 2);
      if (inw && ev) last_pix = shadow[da];
      else if (!inw) last_pix = BG;
      pq.push_back('{pix: last_pix, vld: inw});
      last_kind = kind;
      @(posedge clk);
      #1;
      e = pq.pop_front();
      $display("cyc f=%0d c=%0d req=%0b slot=%0d addr=%h we=%0b ack=%0b pix=%h vld=%0b",
               f, c, host_req, kind, MemAddr, MemWe, HostAck, Pixel, PixelValid);
      chk("mem_we", 32'(MemWe), 32'(kind == 2));
      chk("host_ack", 32'(HostAck), 32'(kind == 2));
      chk("mem_addr", 32'(MemAddr), 32'(m_addr));
      if (kind == 2) chk("mem_wdata", 32'(MemWdata), 32'(m_wdata));
      chk("pixel", 32'(Pixel), 32'(e.pix));
      chk("pixel_valid", 32'(PixelValid), 32'(e.vld));
   endtask

   task automatic host_update();
      if (m_ack) begin
         if ($urandom_range(0, 1) == 0) begin
            host_req = 1'b0;
         end else begin
            host_addr = 16'($urandom);
            host_data = 8'($urandom);
         end
      end else if (!host_req && $urandom_range(0, 2) == 0) begin
         host_req  = 1'b1;
         host_addr = 16'($urandom);
         host_data = 8'($urandom);
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) shadow[i] = init_val(i);
      model_reset();
      do_reset();

      // First visible pixel reads address 0, then doubles horizontally.
      do_cycle(35, 216);
      chk("first_rd_addr", 32'(MemAddr), 32'h0000);
      do_cycle(35, 217);
      do_cycle(35, 218);
      chk("first_pixel", 32'(Pixel), 32'hA5);
      do_cycle(35, 219);
      chk("odd_hold_pixel", 32'(Pixel), 32'hA5);

      do_cycle(38, 221);
      do_cycle(38, 222);
      chk("rd_addr_0103", 32'(MemAddr), 32'h0103);

      // Blanking host writes with request held: acks every other cycle.
      host_req  = 1'b1;
      host_addr = 16'h1234;
      host_data = 8'h5A;
      do_cycle(10, 100);
      chk("host_wr_addr", 32'(MemAddr), 32'h1234);
      chk("host_wr_data", 32'(MemWdata), 32'h5A);
      chk("host_ack_pulse", 32'(HostAck), 32'h1);
      do_cycle(10, 101);
      chk("host_no_b2b", 32'(HostAck), 32'h0);
      do_cycle(10, 102);
      chk("host_reack", 32'(HostAck), 32'h1);

      // In-window sweep with a continuously pending host request.
      for (int c = 210; c < 736; c++) begin
         do_cycle(40, c);
         if (m_ack) begin
            host_addr = 16'($urandom);
            host_data = 8'($urandom);
         end
      end
      host_req = 1'b0;

      do_cycle(35, 215);
      do_cycle(35, 728);
      do_cycle(34, 300);
      do_cycle(547, 300);
      do_cycle(546, 727);

      // Reset while a grant is on the bus.
      host_req  = 1'b1;
      host_addr = 16'h00FF;
      host_data = 8'h3C;
      do_cycle(10, 50);
      if (!m_ack) do_cycle(10, 51);
      do_reset();
      do_cycle(36, 216);
      do_cycle(36, 217);
      do_cycle(36, 218);
      do_cycle(36, 219);

      for (int blk = 0; blk < 40; blk++) begin
         int f;
         int c0;
         int len;
         f   = $urandom_range(20, 560);
         c0  = $urandom_range(200, 700);
         len = $urandom_range(10, 80);
         if (blk == 20) do_reset();
         for (int j = 0; j < len; j++) begin
            int c;
            c = c0 + j;
            if ($urandom_range(0, 15) == 0) c = $urandom_range(0, 2047);
            do_cycle(f, c);
            host_update();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pix_mem_sched.md
Name: pix_mem_sched

Overview:
- Cycle-by-cycle scheduler for the single-port image memory behind the pixel addressing stage.
- Generates display read slots from the beam position (Filas/Columnas, row/column doubled, X-Y addressing {m,n}).
- Shares free slots with a host loader that writes image data through a req/ack handshake.
- Sits between the VGA timing generator, the image RAM and the colour output stage.

Parameters:
- H_START, 216, first visible image column.
- V_START, 35, first visible image row.
- IMG_W, 256, source image width in pixels (power of two); displayed width is 2*IMG_W.
- IMG_H, 256, source image height in pixels (power of two); displayed height is 2*IMG_H.
- BG_COLOR, 8'h00, pixel value driven outside the image window.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- Filas  in  10  current beam row from the timing generator.
- Columnas  in  11  current beam column from the timing generator.
- HostReq  in  1  host write request; held until HostAck.
- HostAddr  in  16  host write address {row[7:0], col[7:0]}.
- HostData  in  8  host write data.
- HostAck  out  1  one-cycle grant pulse; the write is issued in that cycle.
- MemAddr  out  16  memory address (registered).
- MemWe  out  1  memory write enable (registered).
- MemWdata  out  8  memory write data (registered).
- MemRdata  in  8  synchronous read data, valid one cycle after MemAddr.
- Pixel  out  8  output pixel.
- PixelValid  out  1  Pixel comes from the image (not BG_COLOR).

Behaviour:
- Reset (async, rst_n=0): MemAddr=0, MemWe=0, MemWdata=0, HostAck=0, Pixel=BG_COLOR, PixelValid=0, slot state=IDLE.
- Window decode (combinational): InWin = (V_START <= Filas < V_START+2*IMG_H) and (H_START <= Columnas < H_START+2*IMG_W).
  - dr = Filas-V_START; dc = Columnas-H_START.
  - m = dr>>1 and n = dc>>1, each truncated to 8 bits; DispAddr = {m,n}.
  - Even = (dc[0]==0).
- Slot decision, registered at each rising edge into a 3-state slot FSM (IDLE, RD, WR):
  - InWin and Even -> RD: MemAddr=DispAddr, MemWe=0.
  - Otherwise, if HostReq=1 and HostAck was 0 in the previous cycle -> WR: MemAddr=HostAddr, MemWdata=HostData, MemWe=1, HostAck=1.
  - Otherwise -> IDLE: MemWe=0, HostAck=0, MemAddr holds.
- Display always has priority; a host write never displaces a display read.
- No back-to-back grants. After an ack, the next grant comes no earlier than two cycles later, so the requester can drop or update HostReq.
- Pixel path has a fixed latency of 2 cycles from the Filas/Columnas sample:
  - The input that produced RD is followed one cycle later by MemRdata, registered into Pixel at the next edge.
  - An odd-column in-window input holds Pixel (horizontal doubling).
  - An out-of-window input drives Pixel=BG_COLOR, PixelValid=0, 2 cycles later.
  - PixelValid mirrors InWin delayed by 2 cycles.
- Boundaries:
  - Last window column (dc=2*IMG_W-1) is odd, so no read; the next column is out of window.
  - Filas/Columnas values below the start offsets never wrap into the window; they are out of window.
  - HostAddr is not range-checked.
  - Reset mid-handshake drops the pending grant; HostReq is re-evaluated after release.
  - Reset mid-line restarts the 2-cycle pipeline with BG_COLOR.

Optional Feature:
- Macro SCHED_BLANK_ONLY_EN.
- Defined: host writes are granted only when InWin=0, so no tearing; odd in-window slots stay IDLE.
- Undefined: host writes may also use odd in-window slots, per the rules above.

Decomposition:
- Package pix_sched_pkg holds:
  - address/data widths (16/8);
  - default timing constants (H_START, V_START, IMG_W, IMG_H);
  - slot state enum {IDLE, RD, WR}.
- One natural sub-module: pix_win_dec, a combinational window decode producing InWin, Even and DispAddr.

Test Plan:
- Reset, then Filas=35/Columnas=216 -> next edge MemAddr=16'h0000, MemWe=0; MemRdata=8'hA5 -> Pixel=8'hA5, PixelValid=1 two cycles after input; Columnas=217 -> Pixel stays 8'hA5.
- Filas=38, Columnas=221 (dc odd) -> no read; Columnas=222 -> MemAddr=16'h0103.
- Filas=10 (blanking), HostReq=1, HostAddr=16'h1234, HostData=8'h5A -> next edge MemWe=1, MemAddr=16'h1234, MemWdata=8'h5A, HostAck=1 for exactly one cycle; with HostReq held, the next ack comes ≥2 cycles later.
- In-window sweep with HostReq=1 -> every even column is RD; writes land only on odd columns (macro undefined); none land in-window with SCHED_BLANK_ONLY_EN.
- Filas=35, Columnas=215 and Columnas=728 -> PixelValid=0, Pixel=BG_COLOR, no RD slot.
- rst_n low for one cycle mid-window during a WR grant -> all outputs at reset values asynchronously, no HostAck; after release, normal RD slots resume on the next even column.
